// File: rtl/branch_predictor_pkg.sv
// Shared constants, counter encodings and PC field helpers for the next-PC predictor.
package branch_predictor_pkg;

    localparam int DBITS     = 32;
    localparam int INDEXBITS = 6;
    localparam int ENTRIES   = 1 << INDEXBITS;
    localparam int TAGBITS   = DBITS - INDEXBITS - 2;

    localparam logic [DBITS-1:0] INSTSIZE = 32'd4;
    localparam logic [DBITS-1:0] STARTPC  = 32'h0000_0100;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [INDEXBITS-1:0] pc_index(input logic [DBITS-1:0] pc);
        return pc[INDEXBITS+1:2];
    endfunction

    function automatic logic [TAGBITS-1:0] pc_tag(input logic [DBITS-1:0] pc);
        return pc[DBITS-1:INDEXBITS+2];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and ALU-side update signals of the branch predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [DBITS-1:0] pc_F;
    logic [DBITS-1:0] pcpred_F;
    logic             predhit_F;
    logic             predtaken_F;
    logic             upd_en;
    logic [DBITS-1:0] upd_pc;
    logic             upd_isctl;
    logic             upd_taken;
    logic [DBITS-1:0] upd_target;
    logic             flush_all;

    modport master (
        output pc_F, upd_en, upd_pc, upd_isctl, upd_taken, upd_target, flush_all,
        input  pcpred_F, predhit_F, predtaken_F
    );

    modport slave (
        input  pc_F, upd_en, upd_pc, upd_isctl, upd_taken, upd_target, flush_all,
        output pcpred_F, predhit_F, predtaken_F
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating taken counter next-state: no wrap at either end.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on pc_F, update on the clock edge.
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic               clk,
    input  logic               RESET_N,
    branch_predictor_if.slave  bp
);

    logic               ent_valid  [ENTRIES];
    logic [TAGBITS-1:0] ent_tag    [ENTRIES];
    logic [DBITS-1:0]   ent_target [ENTRIES];
    logic [1:0]         ent_ctr    [ENTRIES];

    logic [INDEXBITS-1:0] look_idx;
    logic [TAGBITS-1:0]   look_tag;
    logic [INDEXBITS-1:0] upd_idx;
    logic [TAGBITS-1:0]   upd_tag;
    logic                 upd_fire;
    logic                 upd_hit;
    logic [1:0]           upd_ctr_next;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{bp.pc_F[1:0], bp.upd_pc[1:0]};

    // Lookup reads the current (pre-update) entry; no bypass of a same-cycle update.
    assign look_idx       = pc_index(bp.pc_F);
    assign look_tag       = pc_tag(bp.pc_F);
    assign bp.predhit_F   = ent_valid[look_idx] && (ent_tag[look_idx] == look_tag);
    assign bp.predtaken_F = bp.predhit_F && ent_ctr[look_idx][1];
    assign bp.pcpred_F    = bp.predtaken_F ? ent_target[look_idx] : bp.pc_F + INSTSIZE;

    assign upd_idx  = pc_index(bp.upd_pc);
    assign upd_tag  = pc_tag(bp.upd_pc);
    assign upd_fire = bp.upd_en && bp.upd_isctl;
    assign upd_hit  = ent_valid[upd_idx] && (ent_tag[upd_idx] == upd_tag);

    bp_sat_counter u_sat_counter (
        .ctr      (ent_ctr[upd_idx]),
        .taken    (bp.upd_taken),
        .ctr_next (upd_ctr_next)
    );

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        localparam logic [INDEXBITS-1:0] IDX = INDEXBITS'(gi);

        logic               valid_q,  valid_d;
        logic [TAGBITS-1:0] tag_q,    tag_d;
        logic [DBITS-1:0]   target_q, target_d;
        logic [1:0]         ctr_q,    ctr_d;

        // Flush only clears valid; a miss-not-taken update leaves the entry alone.
        always_comb begin
            valid_d  = valid_q;
            tag_d    = tag_q;
            target_d = target_q;
            ctr_d    = ctr_q;
            if (bp.flush_all) begin
                valid_d = 1'b0;
            end else if (upd_fire && (upd_idx == IDX)) begin
                if (upd_hit) begin
                    ctr_d = upd_ctr_next;
                    if (bp.upd_taken) target_d = bp.upd_target;
                end else if (bp.upd_taken) begin
                    valid_d  = 1'b1;
                    tag_d    = upd_tag;
                    target_d = bp.upd_target;
                    ctr_d    = WT;
                end
            end
        end

        always_ff @(posedge clk or negedge RESET_N) begin
            if (!RESET_N) begin
                valid_q  <= 1'b0;
                tag_q    <= '0;
                target_q <= '0;
                ctr_q    <= WNT;
            end else begin
                valid_q  <= valid_d;
                tag_q    <= tag_d;
                target_q <= target_d;
                ctr_q    <= ctr_d;
            end
        end

        assign ent_valid[gi]  = valid_q;
        assign ent_tag[gi]    = tag_q;
        assign ent_target[gi] = target_q;
        assign ent_ctr[gi]    = ctr_q;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized checks of the branch predictor against a table model of its rules.
module tb_branch_predictor;

    logic clk;
    logic RESET_N;
    int   checks = 0;
    int   passes = 0;

    branch_predictor_if bp();

    branch_predictor dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bp      (bp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 64 entries, index = (pc/4) mod 64, tag = pc/256.
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    int unsigned m_target [64];
    int          m_ctr    [64];

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
    endfunction

    function automatic void model_predict(input int unsigned pc, output int unsigned pred,
                                          output bit hit, output bit tk);
        int unsigned idx = (pc / 4) % 64;
        hit  = m_valid[idx] && (m_tag[idx] == pc / 256);
        tk   = hit && (m_ctr[idx] >= 2);
        pred = tk ? m_target[idx] : pc + 4;
    endfunction

    function automatic void model_update(input bit en, input bit isctl, input bit taken,
                                         input int unsigned pc, input int unsigned tgt,
                                         input bit flush);
        int unsigned idx = (pc / 4) % 64;
        bit hit = m_valid[idx] && (m_tag[idx] == pc / 256);
        if (flush) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
        end else if (en && isctl) begin
            if (hit && taken) begin
                m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                m_target[idx] = tgt;
            end else if (hit) begin
                m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end else if (taken) begin
                m_valid[idx] = 1; m_tag[idx] = pc / 256; m_target[idx] = tgt; m_ctr[idx] = 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Pure lookup against constant expectations (no clock edge).
    task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] pred,
                        input logic hit, input logic tk);
        bp.pc_F = pc; bp.upd_en = 1'b0; bp.flush_all = 1'b0;
        #1;
        $display("look %s pc=%h pred=%h hit=%0b taken=%0b", tag, pc,
                 bp.pcpred_F, bp.predhit_F, bp.predtaken_F);
        chk({tag, "_pred"},  bp.pcpred_F, pred);
        chk({tag, "_hit"},   {31'b0, bp.predhit_F}, {31'b0, hit});
        chk({tag, "_taken"}, {31'b0, bp.predtaken_F}, {31'b0, tk});
    endtask

    // One clock: lookup checked against the model's pre-update state, then update applied.
    task automatic step(input string tag, input logic [31:0] pc, input bit en, input bit isctl,
                        input bit taken, input logic [31:0] upc, input logic [31:0] tgt,
                        input bit flush);
        int unsigned pred;
        bit hit, tk;
        bp.pc_F = pc; bp.upd_en = en; bp.upd_isctl = isctl; bp.upd_taken = taken;
        bp.upd_pc = upc; bp.upd_target = tgt; bp.flush_all = flush;
        #1;
        model_predict(pc, pred, hit, tk);
        $display("step %s pc=%h pred=%h hit=%0b taken=%0b | en=%0b ctl=%0b tk=%0b upc=%h tgt=%h fl=%0b",
                 tag, pc, bp.pcpred_F, bp.predhit_F, bp.predtaken_F, en, isctl, taken, upc, tgt, flush);
        chk({tag, "_pred"},  bp.pcpred_F, pred);
        chk({tag, "_hit"},   {31'b0, bp.predhit_F}, {31'b0, hit});
        chk({tag, "_taken"}, {31'b0, bp.predtaken_F}, {31'b0, tk});
        @(posedge clk);
        model_update(en, isctl, taken, upc, tgt, flush);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0;
        bp.pc_F = 32'h100; bp.upd_en = 1'b0; bp.upd_pc = '0; bp.upd_isctl = 1'b0;
        bp.upd_taken = 1'b0; bp.upd_target = '0; bp.flush_all = 1'b0;
        model_reset();

        look("t1_reset", 32'h100, 32'h104, 1'b0, 1'b0);
        @(negedge clk);
        RESET_N = 1'b1;
        @(posedge clk); #1;

        step("t2_alloc", 32'h100, 1, 1, 1, 32'h100, 32'h200, 0);
        look("t2_hit", 32'h100, 32'h200, 1'b1, 1'b1);

        step("t3_nt", 32'h100, 1, 1, 0, 32'h100, 32'h0, 0);
        look("t3_weak", 32'h100, 32'h104, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step("t4_tk", 32'h100, 1, 1, 1, 32'h100, 32'h200, 0);
        step("t4_nt", 32'h100, 1, 1, 0, 32'h100, 32'h0, 0);
        look("t4_sat", 32'h100, 32'h200, 1'b1, 1'b1);
        step("t4_nt2", 32'h100, 1, 1, 0, 32'h100, 32'h0, 0);
        look("t4_wnt", 32'h100, 32'h104, 1'b1, 1'b0);
        step("t4_tk2", 32'h100, 1, 1, 1, 32'h100, 32'h200, 0);

        look("t5_alias_miss", 32'h200, 32'h204, 1'b0, 1'b0);
        step("t5_replace", 32'h200, 1, 1, 1, 32'h200, 32'h300, 0);
        look("t5_old_miss", 32'h100, 32'h104, 1'b0, 1'b0);
        look("t5_new_hit", 32'h200, 32'h300, 1'b1, 1'b1);

        // Non-control instructions and stalled slots must leave the table untouched.
        step("t6_noctl", 32'h200, 1, 0, 1, 32'h240, 32'h500, 0);
        for (int i = 0; i < 3; i++) step("t6_stall", 32'h200, 0, 1, 0, 32'h200, 32'h0, 0);
        look("t6_frozen", 32'h200, 32'h300, 1'b1, 1'b1);
        look("t6_noalloc", 32'h240, 32'h244, 1'b0, 1'b0);

        // Flush beats a simultaneous allocating update.
        step("t7_flush", 32'h200, 1, 1, 1, 32'h300, 32'h400, 1);
        look("t7_flushed", 32'h200, 32'h204, 1'b0, 1'b0);
        look("t7_no_alloc", 32'h300, 32'h304, 1'b0, 1'b0);

        // Asynchronous reset mid-run with a pending update.
        step("t8_alloc", 32'h200, 1, 1, 1, 32'h200, 32'h300, 0);
        bp.pc_F = 32'h200; bp.upd_en = 1'b1; bp.upd_isctl = 1'b1; bp.upd_taken = 1'b1;
        bp.upd_pc = 32'h300; bp.upd_target = 32'h400;
        #1;
        chk("t8_pre_reset", bp.pcpred_F, 32'h300);
        RESET_N = 1'b0;
        #1;
        chk("t8_async_pred", bp.pcpred_F, 32'h204);
        chk("t8_async_hit", {31'b0, bp.predhit_F}, 32'h0);
        model_reset();
        @(posedge clk); #2;
        RESET_N = 1'b1;
        look("t8_discard", 32'h300, 32'h304, 1'b0, 1'b0);
        look("t8_cleared", 32'h200, 32'h204, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic over a few aliasing tags and indices.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] upc, lpc, tgt;
            bit en, ctl, tk, fl;
            upc = ($urandom_range(1, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            lpc = ($urandom_range(0, 1) == 1) ? upc
                : (($urandom_range(1, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            tgt = $urandom;
            en  = ($urandom_range(0, 3) != 0);
            ctl = ($urandom_range(0, 3) != 0);
            tk  = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 49) == 0);
            step("rnd", lpc, en, ctl, tk, upc, tgt, fl);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
